// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: select codes, funct codes, alu_op classes and FSM
// state shared by alu_ctrl_seq, alu_ctrl_decode and the bus interface.
package alu_ctrl_pkg;

  localparam int unsigned SEL_ADD  = 0;
  localparam int unsigned SEL_SUB  = 1;
  localparam int unsigned SEL_AND  = 2;
  localparam int unsigned SEL_OR   = 3;
  localparam int unsigned SEL_SLL  = 4;
  localparam int unsigned SEL_SRL  = 5;
  localparam int unsigned SEL_SLT  = 6;
  localparam int unsigned SEL_MULT = 7;
  localparam int unsigned SEL_DIV  = 8;
  localparam int unsigned SEL_NOR  = 9;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_DIV  = 6'h1A;
  localparam logic [5:0] FN_NOR  = 6'h27;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_RTYPE = 3'd2;
  localparam logic [2:0] OP_AND   = 3'd3;
  localparam logic [2:0] OP_OR    = 3'd4;
  localparam logic [2:0] OP_SLT   = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// alu_ctrl_seq_if: request/response handshake bundle of alu_ctrl_seq.
// master drives requests and out_ready; slave is the control unit.
interface alu_ctrl_seq_if #(
  parameter int SEL_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_op;
  logic [5:0]       funct;
  logic             out_valid;
  logic             out_ready;
  logic [SEL_W-1:0] select;
  logic             illegal;
  logic             hilo_we;
  logic             busy;

  modport master (
    output in_valid, alu_op, funct, out_ready,
    input  in_ready, out_valid, select,
    input  illegal, hilo_we, busy
  );

  modport slave (
    input  in_valid, alu_op, funct, out_ready,
    output in_ready, out_valid, select,
    output illegal, hilo_we, busy
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational (alu_op, funct) -> (select, illegal,
// is_mult, is_div). funct 0x1A is DIV only when ALU_CTRL_DIV_EN is set.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int SEL_W = 4
) (
  input  logic [2:0]       alu_op,
  input  logic [5:0]       funct,
  output logic [SEL_W-1:0] select,
  output logic             illegal,
  output logic             is_mult,
  output logic             is_div
);

  logic [SEL_W-1:0] fn_sel;
  logic             fn_ill;
  logic             fn_mult;
  logic             fn_div;

  always_comb begin
    fn_sel  = '0;
    fn_ill  = 1'b0;
    fn_mult = 1'b0;
    fn_div  = 1'b0;
    unique case (1'b1)
      (funct == FN_ADD): fn_sel = SEL_W'(SEL_ADD);
      (funct == FN_SUB): fn_sel = SEL_W'(SEL_SUB);
      (funct == FN_AND): fn_sel = SEL_W'(SEL_AND);
      (funct == FN_OR):  fn_sel = SEL_W'(SEL_OR);
      (funct == FN_SLL): fn_sel = SEL_W'(SEL_SLL);
      (funct == FN_SRL): fn_sel = SEL_W'(SEL_SRL);
      (funct == FN_SLT): fn_sel = SEL_W'(SEL_SLT);
      (funct == FN_NOR): fn_sel = SEL_W'(SEL_NOR);
      (funct == FN_MULT): begin
        fn_sel  = SEL_W'(SEL_MULT);
        fn_mult = 1'b1;
      end
`ifdef ALU_CTRL_DIV_EN
      (funct == FN_DIV): begin
        fn_sel = SEL_W'(SEL_DIV);
        fn_div = 1'b1;
      end
`endif
      default: fn_ill = 1'b1;
    endcase
  end

  always_comb begin
    select  = '0;
    illegal = 1'b0;
    is_mult = 1'b0;
    is_div  = 1'b0;
    unique case (1'b1)
      (alu_op == OP_ADD): select = SEL_W'(SEL_ADD);
      (alu_op == OP_SUB): select = SEL_W'(SEL_SUB);
      (alu_op == OP_AND): select = SEL_W'(SEL_AND);
      (alu_op == OP_OR):  select = SEL_W'(SEL_OR);
      (alu_op == OP_SLT): select = SEL_W'(SEL_SLT);
      (alu_op == OP_RTYPE): begin
        select  = fn_sel;
        illegal = fn_ill;
        is_mult = fn_mult;
        is_div  = fn_div;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered valid/ready ALU control with MULT/DIV sequencing.
// Ports: clk, rst (sync, active-high), io (alu_ctrl_seq_if.slave).
// ALU_CTRL_DIV_EN enables DIV decode and DIV_LAT occupancy.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int SEL_W   = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8
) (
  input  logic         clk,
  input  logic         rst,
  alu_ctrl_seq_if.slave io
);

`ifdef ALU_CTRL_DIV_EN
  localparam int MAX_LAT = max_i(MUL_LAT, DIV_LAT);
  localparam int DIV_CYC = DIV_LAT;
`else
  // DIV never decodes here, so DIV_LAT has no effect on the build.
  localparam int MAX_LAT = MUL_LAT;
  localparam int DIV_CYC = DIV_LAT - DIV_LAT + 1;
`endif
  localparam int CNT_W = $clog2(MAX_LAT + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             ill_q, ill_d;
  logic             hilo_q, hilo_d;

  logic [SEL_W-1:0] dec_sel;
  logic             dec_ill;
  logic             dec_mult;
  logic             dec_div;
  logic             load;
  int               op_lat;

  alu_ctrl_decode #(
    .SEL_W(SEL_W)
  ) u_dec (
    .alu_op (io.alu_op),
    .funct  (io.funct),
    .select (dec_sel),
    .illegal(dec_ill),
    .is_mult(dec_mult),
    .is_div (dec_div)
  );

  assign io.in_ready  = (state_q == ST_IDLE)
                      | ((state_q == ST_DONE) & io.out_ready);
  assign io.out_valid = (state_q == ST_DONE);
  assign io.busy      = (state_q == ST_WAIT);
  assign io.select    = sel_q;
  assign io.illegal   = ill_q;
  assign io.hilo_we   = hilo_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    ill_d   = ill_q;
    hilo_d  = hilo_q;
    load    = 1'b0;
    op_lat  = dec_mult ? MUL_LAT : DIV_CYC;
    unique case (state_q)
      ST_IDLE: load = io.in_valid;
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
          hilo_d  = 1'b1;
        end
      end
      ST_DONE: begin
        if (io.out_ready) begin
          if (io.in_valid) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
            hilo_d  = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      sel_d  = dec_sel;
      ill_d  = dec_ill;
      hilo_d = 1'b0;
      cnt_d  = '0;
      if ((dec_mult | dec_div) && (op_lat > 1)) begin
        state_d = ST_WAIT;
        cnt_d   = CNT_W'(op_lat - 1);
      end else begin
        // Single-cycle MDU ops strobe HI/LO immediately.
        state_d = ST_DONE;
        hilo_d  = dec_mult | dec_div;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      ill_q   <= 1'b0;
      hilo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      ill_q   <= ill_d;
      hilo_q  <= hilo_d;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: scenario tasks plus a randomized run against a
// transaction-level model of the control unit.
module tb_alu_ctrl_seq;

  localparam int SEL_W   = 4;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 8;
  localparam int OW      = SEL_W + 4;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic             ill;
    logic             mdu;
    logic [7:0]       lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  alu_ctrl_seq_if #(.SEL_W(SEL_W)) bus ();

  alu_ctrl_seq #(
    .SEL_W  (SEL_W),
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (bus)
  );

  always #5 clk = ~clk;

  logic [OW-1:0] obs;
  assign obs = {bus.out_valid, bus.select, bus.illegal,
                bus.hilo_we, bus.busy};

  function automatic logic [OW-1:0] pk(input logic v,
    input logic [SEL_W-1:0] s, input logic i,
    input logic h, input logic b);
    return {v, s, i, h, b};
  endfunction

  // Reference decode straight from the operation tables.
  function automatic exp_t ref_dec(input logic [2:0] op,
                                   input logic [5:0] fn);
    exp_t e;
    e = '{sel: '0, ill: 1'b0, mdu: 1'b0, lat: 8'd1};
    case (op)
      3'd0: e.sel = 4'd0;
      3'd1: e.sel = 4'd1;
      3'd3: e.sel = 4'd2;
      3'd4: e.sel = 4'd3;
      3'd5: e.sel = 4'd6;
      3'd2: begin
        case (fn)
          6'h20: e.sel = 4'd0;
          6'h22: e.sel = 4'd1;
          6'h24: e.sel = 4'd2;
          6'h25: e.sel = 4'd3;
          6'h00: e.sel = 4'd4;
          6'h02: e.sel = 4'd5;
          6'h2A: e.sel = 4'd6;
          6'h27: e.sel = 4'd9;
          6'h18: begin
            e.sel = 4'd7; e.mdu = 1'b1; e.lat = 8'(MUL_LAT);
          end
`ifdef ALU_CTRL_DIV_EN
          6'h1A: begin
            e.sel = 4'd8; e.mdu = 1'b1; e.lat = 8'(DIV_LAT);
          end
`endif
          default: e.ill = 1'b1;
        endcase
      end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.alu_op = 3'd0;
    bus.funct = 6'h0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (obs !== '0) begin
        bad++;
        $display("FAIL reset.outs got=%h exp=0", obs);
      end
    end
    rst = 1'b0;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset.in_ready got=%b exp=1", bus.in_ready);
    end
  endtask

  task automatic test_single();
    exp_t e;
    e = ref_dec(3'd2, 6'h22);
    bus.in_valid = 1'b1;
    bus.alu_op = 3'd2;
    bus.funct = 6'h22;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    total++;
    if (obs !== pk(1'b1, e.sel, 1'b0, 1'b0, 1'b0)) begin
      bad++;
      $display("FAIL single.out got=%h exp=%h", obs,
               pk(1'b1, e.sel, 1'b0, 1'b0, 1'b0));
    end
    tick();
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL single.drop got=%b exp=0", bus.out_valid);
    end
  endtask

  task automatic test_stream();
    logic [5:0] fns [7];
    exp_t e;
    fns = '{6'h20, 6'h24, 6'h25, 6'h00, 6'h02, 6'h2A, 6'h27};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      e = ref_dec(3'd2, fns[i]);
      bus.in_valid = 1'b1;
      bus.alu_op = 3'd2;
      bus.funct = fns[i];
      #1;
      total++;
      if (bus.in_ready !== 1'b1) begin
        bad++;
        $display("FAIL stream.ready[%0d] got=%b exp=1", i, bus.in_ready);
      end
      tick();
      total++;
      if (obs !== pk(1'b1, e.sel, 1'b0, 1'b0, 1'b0)) begin
        bad++;
        $display("FAIL stream.out[%0d] got=%h exp=%h", i, obs,
                 pk(1'b1, e.sel, 1'b0, 1'b0, 1'b0));
      end
    end
    bus.in_valid = 1'b0;
    tick();
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL stream.end got=%b exp=0", bus.out_valid);
    end
  endtask

  task automatic test_mult();
    exp_t e;
    int nbusy;
    e = ref_dec(3'd2, 6'h18);
    nbusy = 0;
    bus.in_valid = 1'b1;
    bus.alu_op = 3'd2;
    bus.funct = 6'h18;
    bus.out_ready = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL mult.accept got=%b exp=1", bus.in_ready);
    end
    tick();
    // A competing request during the countdown must be ignored.
    bus.funct = 6'h20;
    for (int c = 1; c < int'(e.lat); c++) begin
      total++;
      if ({bus.out_valid, bus.busy, bus.in_ready} !== 3'b010) begin
        bad++;
        $display("FAIL mult.wait[%0d] got=%b exp=010", c,
                 {bus.out_valid, bus.busy, bus.in_ready});
      end
      if (bus.busy === 1'b1) nbusy++;
      if (c == int'(e.lat) - 1) bus.in_valid = 1'b0;
      tick();
    end
    bus.in_valid = 1'b0;
    total++;
    if (nbusy != int'(e.lat) - 1) begin
      bad++;
      $display("FAIL mult.busy_cnt got=%0d exp=%0d", nbusy,
               int'(e.lat) - 1);
    end
    total++;
    if (obs !== pk(1'b1, e.sel, 1'b0, 1'b1, 1'b0)) begin
      bad++;
      $display("FAIL mult.done got=%h exp=%h", obs,
               pk(1'b1, e.sel, 1'b0, 1'b1, 1'b0));
    end
    tick();
    total++;
    if ({bus.out_valid, bus.hilo_we} !== 2'b00) begin
      bad++;
      $display("FAIL mult.clear got=%b exp=00",
               {bus.out_valid, bus.hilo_we});
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    e = ref_dec(3'd3, 6'h00);
    bus.in_valid = 1'b1;
    bus.alu_op = 3'd3;
    bus.funct = 6'h00;
    bus.out_ready = 1'b0;
    tick();
    bus.alu_op = 3'd4;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if ({obs, bus.in_ready} !==
          {pk(1'b1, e.sel, 1'b0, 1'b0, 1'b0), 1'b0}) begin
        bad++;
        $display("FAIL bp.hold[%0d] got=%h/%b exp=%h/0", c, obs,
                 bus.in_ready, pk(1'b1, e.sel, 1'b0, 1'b0, 1'b0));
      end
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp.release got=%b exp=1", bus.in_ready);
    end
    tick();
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp.drain got=%b exp=0", bus.out_valid);
    end
  endtask

  task automatic test_illegal();
    logic [2:0] ops [5];
    logic [5:0] fns [5];
    exp_t e;
    ops = '{3'd2, 3'd7, 3'd6, 3'd2, 3'd2};
    fns = '{6'h3F, 6'h20, 6'h00, 6'h1A, 6'h01};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      e = ref_dec(ops[i], fns[i]);
      if (e.lat > 8'd1) continue;
      bus.in_valid = 1'b1;
      bus.alu_op = ops[i];
      bus.funct = fns[i];
      tick();
      total++;
      if (obs !== pk(1'b1, e.sel, e.ill, e.mdu, 1'b0)) begin
        bad++;
        $display("FAIL illegal[%0d] got=%h exp=%h", i, obs,
                 pk(1'b1, e.sel, e.ill, e.mdu, 1'b0));
      end
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic [5:0] fn;
    e = ref_dec(3'd2, 6'h1A);
    fn = (e.lat > 8'd1) ? 6'h1A : 6'h18;
    e = ref_dec(3'd2, fn);
    bus.in_valid = 1'b1;
    bus.alu_op = 3'd2;
    bus.funct = fn;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    total++;
    if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin
      bad++;
      $display("FAIL rstmid.after got=%b exp=100",
               {bus.in_ready, bus.out_valid, bus.busy});
    end
    for (int c = 0; c < int'(e.lat) + 2; c++) begin
      tick();
      total++;
      if (bus.out_valid !== 1'b0) begin
        bad++;
        $display("FAIL rstmid.valid[%0d] got=%b exp=0", c,
                 bus.out_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] pool [10];
    bit   has, ev, eb, er, acc;
    int   rem;
    exp_t cur, nx;
    int   op;
    pool = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h00,
             6'h02, 6'h2A, 6'h18, 6'h1A, 6'h27};
    has = 1'b0;
    rem = 0;
    cur = '0;
    for (int c = 0; c < 400; c++) begin
      ev = has && (rem == 0);
      eb = has && (rem > 0);
      total++;
      if ({bus.out_valid, bus.busy} !== {ev, eb}) begin
        bad++;
        $display("FAIL rand.state[%0d] got=%b%b exp=%b%b", c,
                 bus.out_valid, bus.busy, ev, eb);
      end
      if (ev) begin
        total++;
        if ({bus.select, bus.illegal, bus.hilo_we} !==
            {cur.sel, cur.ill, cur.mdu}) begin
          bad++;
          $display("FAIL rand.data[%0d] got=%h exp=%h", c,
                   {bus.select, bus.illegal, bus.hilo_we},
                   {cur.sel, cur.ill, cur.mdu});
        end
      end
      op = $urandom_range(0, 10);
      bus.alu_op = (op > 7) ? 3'd2 : 3'(op);
      bus.funct = ($urandom_range(0, 9) < 7) ?
                  pool[$urandom_range(0, 9)] : 6'($urandom);
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      er = !has || (ev && bus.out_ready);
      total++;
      if (bus.in_ready !== er) begin
        bad++;
        $display("FAIL rand.ready[%0d] got=%b exp=%b", c,
                 bus.in_ready, er);
      end
      acc = bus.in_valid && er;
      nx = ref_dec(bus.alu_op, bus.funct);
      if (eb) rem--;
      else if (ev && bus.out_ready && !acc) has = 1'b0;
      if (acc) begin
        has = 1'b1;
        cur = nx;
        rem = int'(nx.lat) - 1;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < DIV_LAT + 2; c++) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_mult();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
